// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
//
// Output-stationary ROWS x COLS systolic matrix multiplier computing C = A * B.
// A is streamed one column per beat (a_col) and B one row per beat (b_row). a
// values move left to right and b values move top to bottom, one register per
// hop. Each PE(r,j) keeps its own accumulator. The input skew is applied
// internally. After K beats the array drains for ROWS+COLS-2 cycles, and then
// the C rows are presented one per handshake.
//
// Configuration macro:
//   SYSTOLIC_SAT_EN  - when defined, each accumulate step saturates to the
//                      signed ACC_WIDTH range. When undefined, it wraps.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   launch a job (sampled only in IDLE)
//   k_len      in   inner dimension K, latched on an accepted start
//   in_valid   in   a_col/b_row beat valid
//   in_ready   out  beat accepted (LOAD only)
//   a_col      in   column k of A, element r at [r*DATA_WIDTH +: DATA_WIDTH]
//   b_row      in   row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   res_valid  out  result row valid
//   res_ready  in   consumer accepts the result row
//   res_data   out  C row, element j at [j*ACC_WIDTH +: ACC_WIDTH]
//   res_last   out  final row (r = ROWS-1)
//   busy       out  high whenever the engine is not IDLE
//   done       out  one-cycle pulse after the final row handshake
// -----------------------------------------------------------------------------
module systolic_mm_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              k_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]      a_col,
    input  logic [COLS*DATA_WIDTH-1:0]      b_row,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [COLS*ACC_WIDTH-1:0]       res_data,
    output logic                            res_last,
    output logic                            busy,
    output logic                            done
);

    localparam int DRAIN_LEN  = ROWS + COLS - 2;
    localparam int DRAIN_LAST = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;
    localparam int DC_W       = $clog2(ROWS + COLS);
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [K_WIDTH-1:0] k_len_q;
    logic [K_WIDTH-1:0] beat_cnt;
    logic [DC_W-1:0]    drain_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic               done_q;

    logic start_acc;
    logic beat_acc;
    logic advance;
    logic last_beat;
    logic drain_last;
    logic row_hs;
    logic last_row;

    // Operands seen by each PE in the current cycle, plus every PE's accumulator.
    logic signed [DATA_WIDTH-1:0] a_flow [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_flow [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_w  [ROWS][COLS];

    assign start_acc  = (state == IDLE) && start;
    assign beat_acc   = (state == LOAD) && in_valid;
    assign advance    = beat_acc || (state == DRAIN);
    assign last_beat  = beat_acc && ((beat_cnt + K_WIDTH'(1)) == k_len_q);
    assign drain_last = (drain_cnt == DC_W'(DRAIN_LAST));
    assign row_hs     = (state == OUTPUT) && res_ready;
    assign last_row   = (row_cnt == ROW_W'(ROWS - 1));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        res_last  = 1'b0;
        busy      = 1'b1;
        done      = done_q;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (k_len == '0) ? OUTPUT : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = (DRAIN_LEN == 0) ? OUTPUT : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                res_last  = last_row;
                if (res_ready && last_row) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= row_hs && last_row;
            if (start_acc) begin
                k_len_q   <= k_len;
                beat_cnt  <= '0;
                drain_cnt <= '0;
                row_cnt   <= '0;
            end else begin
                if (beat_acc) begin
                    beat_cnt <= beat_cnt + K_WIDTH'(1);
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + DC_W'(1);
                end
                if (row_hs) begin
                    row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------- input skew
    // Lane r of a (lane j of b) passes through r (j) registers. The registers
    // step only when the array advances, so gaps in the beats keep alignment.
    // Zeros are injected outside LOAD, so the drain pushes no stale operands.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_skew
        logic signed [DATA_WIDTH-1:0] a_new;
        assign a_new = (state == LOAD) ? a_col[gr*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (gr == 0) begin : g_direct
            assign a_flow[gr][0] = a_new;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] sr [gr];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < gr; i++) sr[i] <= '0;
                end else if (start_acc) begin
                    for (int unsigned i = 0; i < gr; i++) sr[i] <= '0;
                end else if (advance) begin
                    sr[0] <= a_new;
                    for (int unsigned i = 1; i < gr; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_flow[gr][0] = sr[gr-1];
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_b_skew
        logic signed [DATA_WIDTH-1:0] b_new;
        assign b_new = (state == LOAD) ? b_row[gc*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (gc == 0) begin : g_direct
            assign b_flow[0][gc] = b_new;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] sr [gc];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < gc; i++) sr[i] <= '0;
                end else if (start_acc) begin
                    for (int unsigned i = 0; i < gc; i++) sr[i] <= '0;
                end else if (advance) begin
                    sr[0] <= b_new;
                    for (int unsigned i = 1; i < gc; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_flow[0][gc] = sr[gc-1];
        end
    end

    // ------------------------------------------------------------ PE array
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0]    prod_ext;
            logic signed [ACC_WIDTH-1:0]    acc_q;
            logic signed [ACC_WIDTH-1:0]    acc_nxt;

            assign prod     = a_flow[gr][gc] * b_flow[gr][gc];
            assign prod_ext = ACC_WIDTH'(prod);

`ifdef SYSTOLIC_SAT_EN
            logic [ACC_WIDTH:0] wide;
            assign wide = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
            // The two top bits differ only on overflow, and the top bit gives its direction.
            always_comb begin
                acc_nxt = wide[ACC_WIDTH-1:0];
                if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                    acc_nxt = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end
`else
            assign acc_nxt = acc_q + prod_ext;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (start_acc) begin
                    acc_q <= '0;
                end else if (advance) begin
                    acc_q <= acc_nxt;
                end
            end
            assign acc_w[gr][gc] = acc_q;

            if (gc < COLS - 1) begin : g_a_hop
                logic signed [DATA_WIDTH-1:0] a_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                    end else if (start_acc) begin
                        a_q <= '0;
                    end else if (advance) begin
                        a_q <= a_flow[gr][gc];
                    end
                end
                assign a_flow[gr][gc+1] = a_q;
            end

            if (gr < ROWS - 1) begin : g_b_hop
                logic signed [DATA_WIDTH-1:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        b_q <= '0;
                    end else if (start_acc) begin
                        b_q <= '0;
                    end else if (advance) begin
                        b_q <= b_flow[gr][gc];
                    end
                end
                assign b_flow[gr+1][gc] = b_q;
            end
        end
    end

    // ------------------------------------------------------------ result mux
    // The accumulators are frozen in OUTPUT, so the selected row stays stable under back-pressure.
    always_comb begin
        res_data = '0;
        if (state == OUTPUT) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (row_cnt == ROW_W'(r)) begin
                    for (int unsigned j = 0; j < COLS; j++) begin
                        res_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[r][j];
                    end
                end
            end
        end
    end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of PE rows (A rows, C rows); legal range 1..16.
REQ-002 SHALL have parameter COLS, default 4, number of PE columns (B columns, C columns); legal range 1..16.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width; ACC_WIDTH >= 2*DATA_WIDTH.
REQ-005 SHALL have parameter K_WIDTH, default 16, width of the inner-dimension length.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port start, input, 1, launches one C = A*B job; sampled only in IDLE.
REQ-009 SHALL have port k_len, input, K_WIDTH, inner dimension K; latched on an accepted start.
REQ-010 SHALL have port in_valid, input, 1, the a_col/b_row beat is valid.
REQ-011 SHALL have port in_ready, output, 1, the engine accepts a beat.
REQ-012 SHALL have port a_col, input, ROWS*DATA_WIDTH, column k of A; element r at [r*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port b_row, input, COLS*DATA_WIDTH, row k of B; element j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port res_valid, output, 1, a result row is valid.
REQ-015 SHALL have port res_ready, input, 1, the consumer accepts the result row.
REQ-016 SHALL have port res_data, output, COLS*ACC_WIDTH, C row; element j at [j*ACC_WIDTH +: ACC_WIDTH].
REQ-017 SHALL have port res_last, output, 1, asserted with the final row (r = ROWS-1).
REQ-018 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-019 SHALL have port done, output, 1, one-cycle pulse at job completion.

Function
REQ-020 SHALL implement an output-stationary ROWS x COLS grid: PE(r,j) accumulates sum over k of A[r][k]*B[k][j]; a flows left to right, b flows top to bottom, with one register per hop.
REQ-021 SHALL skew its inputs internally: a element r delayed r array-advances, b element j delayed j array-advances.
REQ-022 SHALL implement FSM states IDLE, LOAD, DRAIN and OUTPUT.
- IDLE -> LOAD on start when k_len > 0.
- IDLE -> OUTPUT on start when k_len == 0; all results are then 0.
REQ-023 SHALL, on an accepted start, clear every accumulator and every skew/pipeline register.
REQ-024 SHALL drive in_ready = 1 only in LOAD; a beat is accepted when in_valid && in_ready.
REQ-025 SHALL advance the array and skew registers only on an accepted beat while in LOAD; when in_valid is low, all array state is held.
REQ-026 SHALL move LOAD -> DRAIN on the k_len-th accepted beat.
REQ-027 SHALL stay in DRAIN exactly ROWS+COLS-2 cycles, advancing every cycle with zero operands injected; when ROWS+COLS-2 == 0, SHALL go directly to OUTPUT.
REQ-028 SHALL, in OUTPUT, present rows r = 0..ROWS-1 in order, one row per res_valid && res_ready handshake.
REQ-029 SHALL hold res_data and res_last stable while res_valid && !res_ready.
REQ-030 SHALL, after the handshake of the last row, return to IDLE and pulse done for exactly 1 cycle in the following cycle; busy falls in that same cycle.
REQ-031 SHALL ignore start whenever the state is not IDLE.
REQ-032 SHALL compute each product as a full signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH; the accumulator wraps modulo 2^ACC_WIDTH (see REQ-036).

Reset
REQ-033 SHALL, on rst_n low, immediately enter IDLE and clear all accumulators, skew registers and counters; in_ready, res_valid, res_last, busy, done and res_data all SHALL be 0.
REQ-034 SHALL abandon a job when reset is asserted mid-job: no done pulse, and no result is emitted after reset is released.

Configuration
REQ-035 SHALL define macro SYSTOLIC_SAT_EN.
REQ-036 SHALL, with SYSTOLIC_SAT_EN defined, saturate each accumulate step to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; with it undefined, accumulation wraps.

Verification
REQ-037 SHALL cover: defaults, K=1, a_col=all 2, b_row=all 3 -> 4 rows each 6,6,6,6; res_last on row 3; done one cycle after.
REQ-038 SHALL cover: K=4, A = identity, B[k][j] = 10k+j -> C rows equal B rows exactly.
REQ-039 SHALL cover: K=3 with in_valid low for 5 cycles between beats -> same C as with no gaps; in_ready high throughout LOAD.
REQ-040 SHALL cover: res_ready low for 3 cycles on row 1 -> row 1 held stable and no row skipped; start pulsed during OUTPUT ignored.
REQ-041 SHALL cover: k_len=0 -> 4 zero rows then done; rst_n low during DRAIN -> IDLE, all outputs 0, no done.
REQ-042 SHALL cover: DATA_WIDTH=16, ACC_WIDTH=32, K=3, all operands -32768 -> wrap result -1073741824 without SYSTOLIC_SAT_EN; 2147483647 with it.
